// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU definitions: default datapath width, op encodings
//            and the legal-op helper used by yAlu and alu_share_arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == ALU_AND) || (op == ALU_OR) ||
               (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/yAlu.sv
// ============================================================================
// Module   : yAlu
// Purpose  : Combinational ALU: AND, OR, ADD, SUB with a zero flag.
//            Unsupported ops produce a zero result and a cleared flag.
// Ports    : a, b  - operands (WIDTH)
//            op    - operation code (3)
//            z     - result (WIDTH)
//            ex    - 1 iff the op is legal and the result is zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module yAlu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] z,
    output logic             ex
);

    always_comb begin
        z = '0;
        case (op)
            ALU_AND: z = a & b;
            ALU_OR:  z = a | b;
            ALU_ADD: z = a + b;
            ALU_SUB: z = a + ~b + WIDTH'(1);
            default: z = '0;
        endcase
    end

    // An illegal op also yields zero, so the flag must be qualified.
    assign ex = is_legal_op(op) && (z == '0);

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one yAlu between two valid/ready
//            requesters, with a single registered response slot that
//            supports backpressure and per-requester wrapping grant counters.
// Ports    : clk, reset             - clock, async active-high reset
//            rN_valid/rN_ready      - requester N handshake (N = 0,1)
//            rN_a, rN_b, rN_op      - requester N operands and op
//            rsp_valid/rsp_ready    - response slot handshake
//            rsp_id                 - requester owning the response
//            rsp_z, rsp_ex          - result and zero flag
//            rsp_illegal            - op was not AND/OR/ADD/SUB
//            gnt_cnt0, gnt_cnt1     - grant counters (wrap)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [2:0]       r0_op,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [2:0]       r1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_ex,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    logic             valid_q,   valid_d;
    logic             id_q,      id_d;
    logic [WIDTH-1:0] z_q,       z_d;
    logic             ex_q,      ex_d;
    logic             ill_q,     ill_d;
    logic             last_q,    last_d;
    logic [CNT_W-1:0] cnt0_q,    cnt0_d;
    logic [CNT_W-1:0] cnt1_q,    cnt1_d;

    logic             w_free;
    logic             w_gnt_vld;
    logic             w_gnt_sel;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [2:0]       w_alu_op;
    logic [WIDTH-1:0] w_alu_z;
    logic             w_alu_ex;

    assign w_free    = !valid_q || rsp_ready;
    assign w_gnt_vld = r0_valid || r1_valid;
    // Under contention the requester that did not win last time goes next;
    // otherwise the lone valid requester is selected.
    assign w_gnt_sel = (r0_valid && r1_valid) ? ~last_q : r1_valid;

    // Reset is asynchronous, so readies are gated directly by it rather than
    // relying on the cleared slot.
    assign r0_ready = !reset && w_free && w_gnt_vld && !w_gnt_sel;
    assign r1_ready = !reset && w_free && w_gnt_vld &&  w_gnt_sel;
    assign w_accept = (r0_valid && r0_ready) || (r1_valid && r1_ready);

    assign w_alu_a  = w_gnt_sel ? r1_a  : r0_a;
    assign w_alu_b  = w_gnt_sel ? r1_b  : r0_b;
    assign w_alu_op = w_gnt_sel ? r1_op : r0_op;

    yAlu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a  (w_alu_a),
        .b  (w_alu_b),
        .op (w_alu_op),
        .z  (w_alu_z),
        .ex (w_alu_ex)
    );

    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        z_d     = z_q;
        ex_d    = ex_q;
        ill_d   = ill_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (w_accept) begin
            valid_d = 1'b1;
            id_d    = w_gnt_sel;
            z_d     = w_alu_z;
            ex_d    = w_alu_ex;
            ill_d   = !is_legal_op(w_alu_op);
            last_d  = w_gnt_sel;
            if (w_gnt_sel) cnt1_d = cnt1_q + CNT_W'(1);
            else           cnt0_d = cnt0_q + CNT_W'(1);
        end else if (rsp_ready) begin
            // Drain only; data fields keep their last values.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            z_q     <= '0;
            ex_q    <= 1'b0;
            ill_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            z_q     <= z_d;
            ex_q    <= ex_d;
            ill_q   <= ill_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign rsp_valid   = valid_q;
    assign rsp_id      = id_q;
    assign rsp_z       = z_q;
    assign rsp_ex      = ex_q;
    assign rsp_illegal = ill_q;
    assign gnt_cnt0    = cnt0_q;
    assign gnt_cnt1    = cnt1_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench for alu_share_arbiter (CNT_W = 4 so that
//            counter wrap is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             r0_valid, r0_ready;
    logic [WIDTH-1:0] r0_a, r0_b;
    logic [2:0]       r0_op;
    logic             r1_valid, r1_ready;
    logic [WIDTH-1:0] r1_a, r1_b;
    logic [2:0]       r1_op;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_ex, rsp_illegal;
    logic [WIDTH-1:0] rsp_z;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .r0_valid    (r0_valid),
        .r0_ready    (r0_ready),
        .r0_a        (r0_a),
        .r0_b        (r0_b),
        .r0_op       (r0_op),
        .r1_valid    (r1_valid),
        .r1_ready    (r1_ready),
        .r1_a        (r1_a),
        .r1_b        (r1_b),
        .r1_op       (r1_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_z       (rsp_z),
        .rsp_ex      (rsp_ex),
        .rsp_illegal (rsp_illegal),
        .gnt_cnt0    (gnt_cnt0),
        .gnt_cnt1    (gnt_cnt1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic [WIDTH-1:0] z;
        logic             ex;
        logic             ill;
    } vec_t;

    vec_t vecs[9];
    int   cnt0_exp;

    initial begin
        vecs[0] = '{32'd5,        32'd3,        3'd2, 32'd8,        1'b0, 1'b0};
        vecs[1] = '{32'd7,        32'd7,        3'd6, 32'd0,        1'b1, 1'b0};
        vecs[2] = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'd0, 32'h00F000F0, 1'b0, 1'b0};
        vecs[3] = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'd1, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[4] = '{32'd7,        32'd7,        3'd3, 32'd0,        1'b0, 1'b1};
        vecs[5] = '{32'd0,        32'd0,        3'd2, 32'd0,        1'b1, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'd1,        3'd2, 32'd0,        1'b1, 1'b0};
        vecs[7] = '{32'd0,        32'd1,        3'd6, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[8] = '{32'hFFFFFFFF, 32'd5,        3'd7, 32'd0,        1'b0, 1'b1};

        reset = 1'b1; rsp_ready = 1'b1;
        r0_valid = 1'b1; r0_a = '0; r0_b = '0; r0_op = 3'd2;
        r1_valid = 1'b1; r1_a = '0; r1_b = '0; r1_op = 3'd2;

        // Reset state, with both requesters asserting valid.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid),   64'd0);
        check("rst_rsp_id",    64'(rsp_id),      64'd0);
        check("rst_rsp_z",     64'(rsp_z),       64'd0);
        check("rst_rsp_ex",    64'(rsp_ex),      64'd0);
        check("rst_rsp_ill",   64'(rsp_illegal), 64'd0);
        check("rst_cnt0",      64'(gnt_cnt0),    64'd0);
        check("rst_cnt1",      64'(gnt_cnt1),    64'd0);
        check("rst_r0_ready",  64'(r0_ready),    64'd0);
        check("rst_r1_ready",  64'(r1_ready),    64'd0);
        r0_valid = 1'b0; r1_valid = 1'b0;
        reset = 1'b0;

        // Single-requester vectors, one accept per cycle.
        cnt0_exp = 0;
        for (int i = 0; i < 9; i++) begin
            r0_a = vecs[i].a; r0_b = vecs[i].b; r0_op = vecs[i].op; r0_valid = 1'b1;
            #1;
            check($sformatf("v%0d_r0_ready", i), 64'(r0_ready), 64'd1);
            check($sformatf("v%0d_r1_ready", i), 64'(r1_ready), 64'd0);
            @(posedge clk);
            #1;
            r0_valid = 1'b0;
            cnt0_exp++;
            check($sformatf("v%0d_valid", i), 64'(rsp_valid),   64'd1);
            check($sformatf("v%0d_id", i),    64'(rsp_id),      64'd0);
            check($sformatf("v%0d_z", i),     64'(rsp_z),       64'(vecs[i].z));
            check($sformatf("v%0d_ex", i),    64'(rsp_ex),      64'(vecs[i].ex));
            check($sformatf("v%0d_ill", i),   64'(rsp_illegal), 64'(vecs[i].ill));
            check($sformatf("v%0d_cnt0", i),  64'(gnt_cnt0),    64'(cnt0_exp % 16));
        end

        // Asynchronous reset while a response is held.
        rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd1; r0_op = 3'd2;
        r1_valid = 1'b1; r1_a = 32'd10; r1_b = 32'd3; r1_op = 3'd6;
        #2;
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid",   64'(rsp_valid), 64'd0);
        check("mid_rst_r0_rdy",  64'(r0_ready),  64'd0);
        check("mid_rst_r1_rdy",  64'(r1_ready),  64'd0);
        check("mid_rst_cnt0",    64'(gnt_cnt0),  64'd0);
        check("mid_rst_cnt1",    64'(gnt_cnt1),  64'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;

        // Contention: strict alternation starting with requester 0.
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr%0d_r0_ready", i), 64'(r0_ready), 64'(i % 2 == 0));
            check($sformatf("rr%0d_r1_ready", i), 64'(r1_ready), 64'(i % 2 == 1));
            @(posedge clk);
            #1;
            check($sformatf("rr%0d_id", i), 64'(rsp_id), 64'(i % 2));
            check($sformatf("rr%0d_z", i),  64'(rsp_z),  (i % 2 == 0) ? 64'd2 : 64'd7);
        end
        check("rr_cnt0", 64'(gnt_cnt0), 64'd3);
        check("rr_cnt1", 64'(gnt_cnt1), 64'd3);

        // Backpressure: slot full, consumer stalled, r1 waiting.
        rsp_ready = 1'b0;
        r0_valid = 1'b0;
        r1_a = 32'd100; r1_b = 32'd1; r1_op = 3'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp%0d_r0_ready", i), 64'(r0_ready), 64'd0);
            check($sformatf("bp%0d_r1_ready", i), 64'(r1_ready), 64'd0);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_valid", i), 64'(rsp_valid), 64'd1);
            check($sformatf("bp%0d_id", i),    64'(rsp_id),    64'd1);
            check($sformatf("bp%0d_z", i),     64'(rsp_z),     64'd7);
            check($sformatf("bp%0d_cnt1", i),  64'(gnt_cnt1),  64'd3);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_r1_ready", 64'(r1_ready), 64'd1);
        @(posedge clk);
        #1;
        r1_valid = 1'b0;
        check("bp_reload_valid", 64'(rsp_valid), 64'd1);
        check("bp_reload_id",    64'(rsp_id),    64'd1);
        check("bp_reload_z",     64'(rsp_z),     64'd101);
        check("bp_reload_cnt1",  64'(gnt_cnt1),  64'd4);
        @(posedge clk);
        #1;
        check("drain_valid",  64'(rsp_valid), 64'd0);
        check("drain_z_hold", 64'(rsp_z),     64'd101);

        // Counter wrap: 17 accepts from r0 with 4-bit counters.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        r0_valid = 1'b1; r0_a = 32'd2; r0_b = 32'd2; r0_op = 3'd2;
        repeat (17) @(posedge clk);
        #1;
        r0_valid = 1'b0;
        check("wrap_cnt0", 64'(gnt_cnt0), 64'd1);
        check("wrap_cnt1", 64'(gnt_cnt1), 64'd0);
        check("wrap_z",    64'(rsp_z),    64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one yAlu instance between two requesters, e.g. the EX stage and the branch-target unit. Arbitration is round-robin. Each requester uses a valid/ready handshake. The block holds one registered response slot with backpressure and counts grants per requester. It sits in front of the ALU in the pipelined CPU datapath.

Parameters:
WIDTH, 32, operand and result width
CNT_W, 16, width of each per-requester grant counter

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
r0_valid  input  1  requester 0 has a request
r0_ready  output  1  requester 0 request accepted this cycle
r0_a  input  WIDTH  requester 0 operand a
r0_b  input  WIDTH  requester 0 operand b
r0_op  input  3  requester 0 ALU op
r1_valid  input  1  requester 1 has a request
r1_ready  output  1  requester 1 request accepted this cycle
r1_a  input  WIDTH  requester 1 operand a
r1_b  input  WIDTH  requester 1 operand b
r1_op  input  3  requester 1 ALU op
rsp_valid  output  1  response slot full
rsp_ready  input  1  consumer takes the response
rsp_id  output  1  which requester the response belongs to
rsp_z  output  WIDTH  ALU result
rsp_ex  output  1  zero flag: 1 iff result is 0 and the op is legal
rsp_illegal  output  1  op was not AND/OR/ADD/SUB
gnt_cnt0  output  CNT_W  grants given to requester 0, wraps
gnt_cnt1  output  CNT_W  grants given to requester 1, wraps

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset values: rsp_valid=0, rsp_id=0, rsp_z=0, rsp_ex=0, rsp_illegal=0, gnt_cnt0=gnt_cnt1=0, last-grant pointer=1, so requester 0 wins first.
- While reset is high, r0_ready=r1_ready=0.
- A reset asserted mid-operation discards any pending response; there is no replay.
- Slot free: free = !rsp_valid || rsp_ready.
- Grant selection (combinational):
  - Only one requester valid: that requester.
  - Both valid: the requester not equal to the last-grant pointer.
  - Neither valid: no grant.
- rN_ready = free && grant==N. At most one ready is high per cycle.
- Accept = rN_valid && rN_ready. On accept:
  - The ALU result is registered into the response slot.
  - rsp_id=N and rsp_valid=1 at the next edge.
  - The last-grant pointer becomes N.
  - gnt_cntN increments, wrapping modulo 2^CNT_W.
- Latency is 1 cycle from accept to rsp_valid. Throughput is 1 response per cycle while rsp_ready=1.
- Drain without a new accept: rsp_valid && rsp_ready clears rsp_valid at the next edge. The data fields hold their last values.
- Simultaneous drain and accept in one cycle: the slot reloads with the new response and rsp_valid stays 1.
- Stall: rsp_valid=1 && rsp_ready=0 forces both readies low. All rsp_* outputs must stay stable until drained.
- The pointer does not move without an accept, so a requester that is valid but blocked keeps its turn.
- Requester obligations: hold valid, a, b and op stable until ready. Valid must not depend combinationally on ready.
- ALU ops (two's complement, wrap modulo 2^WIDTH, no overflow flag):
  - 0 = a & b
  - 1 = a | b
  - 2 = a + b
  - 6 = a + ~b + 1
- Any other op: rsp_z=0, rsp_ex=0, rsp_illegal=1. The op still completes and still counts as a grant.

Decomposition:
- Shared package alu_pkg holds:
  - op constants ALU_AND=3'd0, ALU_OR=3'd1, ALU_ADD=3'd2, ALU_SUB=3'd6
  - an is_legal_op helper
  - default WIDTH
- The existing yAlu is instantiated once as the sole sub-module.
- A mux in front of yAlu selects the granted requester's operands and op.
- Arbiter, response slot and counters live in alu_share_arbiter.

Test Plan:
- Reset check: assert reset mid-stream while rsp_valid=1 -> within the same cycle, rsp_valid=0, both readies 0, counters 0. After release, the first contested grant goes to r0.
- Single requester: r0 sends a=5, b=3, op=2 -> r0_ready=1 in cycle N. In cycle N+1: rsp_valid=1, rsp_id=0, rsp_z=8, rsp_ex=0, gnt_cnt0=1.
- Round-robin under contention: both valid every cycle, rsp_ready=1, 6 cycles -> rsp_id sequence 0,1,0,1,0,1; gnt_cnt0=gnt_cnt1=3.
- Backpressure: rsp_valid=1 and rsp_ready=0 for 4 cycles with r1 valid -> readies stay 0 and rsp_* is unchanged. Raise rsp_ready -> the slot drains and reloads with r1's response in the same cycle, and rsp_valid stays 1.
- Ops and flags:
  - a=7, b=7, op=6 -> rsp_z=0, rsp_ex=1
  - a=0xF0F0F0F0, b=0x0FF00FF0, op=0 -> rsp_z=0x00F000F0
  - op=1 on the same operands -> rsp_z=0xFFF0FFF0
  - op=3 -> rsp_z=0, rsp_illegal=1, rsp_ex=0, counter still increments
- Counter wrap with CNT_W=4: 17 accepts from r0 -> gnt_cnt0 reads 1.
